br_pre_ctrl_rd: RTL and testbench
=================================

Name: br_pre_ctrl_rd

Overview:
- Consumer stage directly downstream of the bridge pre-processing 1024x40 control FIFO and its companion 64-bit data FIFO.
- Pops one 40-bit packet descriptor, then reads the packet's data beats from the data FIFO and presents them as a framed 64-bit stream (sop/eop/mod) to the MAC TX path.
- Packets with the drop flag set are flushed from the data FIFO without being forwarded.

Parameters:
- DWIDTH, 64, data FIFO / TX data width (fixed at 64; mod arithmetic assumes 8 bytes per beat).
- CWIDTH, 40, control word width.
- LENW, 14, byte-length field width.

Ports:
- clk  in  1  single clock; both FIFO read sides and the TX side.
- reset_  in  1  asynchronous reset, active-low.
- cfifo_rdreq  out  1  control FIFO read request; at most one pulse per packet.
- cfifo_q  in  40  control word, valid 1 cycle after rdreq.
- cfifo_empty  in  1  control FIFO empty.
- dfifo_rdreq  out  1  data FIFO read request.
- dfifo_q  in  64  data word, valid 1 cycle after rdreq.
- dfifo_empty  in  1  data FIFO empty.
- tx_val  out  1  TX beat valid.
- tx_rdy  in  1  TX accept; a beat transfers when tx_val & tx_rdy.
- tx_data  out  64  beat data.
- tx_sop  out  1  first beat of packet.
- tx_eop  out  1  last beat of packet.
- tx_mod  out  3  valid bytes on eop beat; 0 means 8. Driven 0 on non-eop beats.
- tx_tag  out  24  descriptor [39:16]; held for the whole packet.
- tx_crc_ins  out  1  descriptor bit 15; held for the whole packet.
- len_err  out  1  1-cycle pulse when a zero-length descriptor is popped.
- pkt_cnt  out  16  forwarded-packet counter; increments on the eop transfer; wraps.
- drop_cnt  out  16  dropped-packet counter; increments on the last flushed beat; wraps.

Behaviour:
- Descriptor format:
  - [13:0] = byte length L.
  - [14] = drop.
  - [15] = crc_insert.
  - [39:16] = tag.
- Beats per packet: N = (L+7)>>3, computed at 15-bit width. N counter is 12 bits.
- eop mod = L[2:0].
- Reset:
  - All outputs 0.
  - FSM in IDLE.
  - Output buffer empty.
  - Counters 0.
  - Reset mid-packet abandons the packet with no flush. Recovery is the system's responsibility, since the FIFOs are reset together with this block.
- FSM:
  - IDLE: if !cfifo_empty, pulse cfifo_rdreq and go to CWAIT.
  - CWAIT (1 cycle): latch cfifo_q into len/drop/crc/tag and load the beat counter with N.
    - L==0: pulse len_err and return to IDLE. No data is read.
    - drop=1: go to DROP.
    - Otherwise: go to DATA.
  - DATA: issue dfifo_rdreq when all three hold:
    - !dfifo_empty;
    - remaining-to-request > 0;
    - (buffer occupancy + reads in flight) < 2.
    
    Returned words enter a 2-entry output FIFO, tagged with sop (first beat) and eop (last beat) and tx_mod. Go to IDLE when the eop beat transfers on TX.
  - DROP: issue dfifo_rdreq whenever !dfifo_empty and remaining > 0. Returned data is discarded. When the last read returns, increment drop_cnt and go to IDLE. tx_val stays 0 throughout.
- Throughput: sustained 1 beat/cycle when tx_rdy=1 and the data FIFO is non-empty.
- Latency: IDLE with cfifo non-empty, to first tx_val, is 4 cycles minimum:
  - cycle 0: cfifo_rdreq
  - cycle 1: CWAIT
  - cycle 2: dfifo_rdreq
  - cycle 3: data captured
  - cycle 4: tx_val
- TX rules:
  - Once tx_val is asserted, tx_data, sop, eop, and mod are held stable until tx_rdy.
  - tx_val never deasserts without a transfer.
- Descriptor pipelining:
  - The next descriptor is not popped until the current packet's eop transfers.
  - No overlap between packets; the inter-packet gap is ≥2 cycles.
- Single-beat packets (L≤8): the beat carries sop=1 and eop=1.
- The block never issues a rdreq while the corresponding empty flag is 1. Underflow is impossible by construction.
- dfifo_empty mid-packet: requests stall, and already-buffered beats still drain to TX.
- Counter wrap: 16'hFFFF + 1 = 0.

Test Plan:
- Single packet, L=20, tag=0xABCDEF, data beats D0..D2, tx_rdy=1:
  - 3 beats D0..D2 in order.
  - sop on D0; eop on D2 with mod=4.
  - tx_tag=0xABCDEF held throughout.
  - pkt_cnt=1.
  - First tx_val 4 cycles after cfifo_rdreq.
- Back-to-back packets L=8 then L=64, tx_rdy=1:
  - Packet 1: one beat with sop=eop=1, mod=0.
  - Packet 2: 8 contiguous beats, 1/cycle.
  - pkt_cnt=2.
- tx_rdy toggling 1,0,0,1 during an L=40 packet:
  - All 5 beats delivered in order.
  - tx_data stable while stalled.
  - Outstanding reads + buffer occupancy never exceed 2.
- Drop descriptor L=24 followed by a normal packet L=16:
  - First 3 data words consumed with tx_val=0; drop_cnt=1.
  - Second packet forwarded correctly starting with data word 4.
- Zero-length descriptor:
  - len_err pulses for 1 cycle.
  - No dfifo_rdreq issued.
  - Next descriptor processed normally.
- dfifo_empty asserted for 5 cycles mid-packet, then reset_ low for 2 cycles mid-packet:
  - No rdreq during empty.
  - Output resumes afterwards.
  - On reset, all outputs and counters read 0 asynchronously, and the FSM is back in IDLE.

Source files
------------

// File: rtl/br_pre_ctrl_rd.sv
// Pops a packet descriptor, then streams its data-FIFO beats to MAC TX as sop/eop/mod frames, or flushes them when drop is set.
// First tx_val 4 cycles after cfifo_rdreq; tx_rdy low holds the 2-entry output buffer and throttles data-FIFO reads.
module br_pre_ctrl_rd #(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 40,
  parameter int LENW   = 14
) (
  input  logic              clk,
  input  logic              reset_,
  output logic              cfifo_rdreq,
  input  logic [CWIDTH-1:0] cfifo_q,
  input  logic              cfifo_empty,
  output logic              dfifo_rdreq,
  input  logic [DWIDTH-1:0] dfifo_q,
  input  logic              dfifo_empty,
  output logic              tx_val,
  input  logic              tx_rdy,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [2:0]        tx_mod,
  output logic [23:0]       tx_tag,
  output logic              tx_crc_ins,
  output logic              len_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, CWAIT, DATA, DROP} state_t;

  typedef struct packed {
    logic [DWIDTH-1:0] dat;
    logic              sop;
    logic              eop;
    logic [2:0]        mod;
  } beat_t;

  state_t      state_q, state_d;
  logic        en_q;
  logic [23:0] tag_q, tag_d;
  logic        crc_q, crc_d;
  logic [2:0]  mod_q, mod_d;
  logic [11:0] req_rem_q, req_rem_d;
  logic [11:0] ret_rem_q, ret_rem_d;
  logic        first_q, first_d;
  logic        rd_pend_q;
  logic [1:0]  occ_q, occ_d;
  beat_t       buf0_q, buf0_d;
  beat_t       buf1_q, buf1_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [LENW-1:0] desc_len;
  logic [11:0]     desc_beats;
  logic            push;
  logic            pop;
  logic            last_ret;
  logic [2:0]      credit_used;
  beat_t           new_beat;

  assign desc_len   = cfifo_q[LENW-1:0];
  assign desc_beats = 12'((15'(desc_len) + 15'd7) >> 3);

  assign tx_val      = (occ_q != 2'd0);
  assign pop         = tx_val & tx_rdy;
  assign push        = rd_pend_q && (state_q == DATA);
  assign last_ret    = (ret_rem_q == 12'd1);
  // Counting this cycle's pop keeps reads flowing at one beat per cycle while
  // buffered plus in-flight words still never exceed two.
  assign credit_used = 3'(occ_q) + 3'(rd_pend_q) - 3'(pop);
  assign new_beat    = '{dat: dfifo_q, sop: first_q, eop: last_ret,
                         mod: (last_ret ? mod_q : 3'd0)};

  always_comb begin
    state_d     = state_q;
    cfifo_rdreq = 1'b0;
    dfifo_rdreq = 1'b0;
    len_err     = 1'b0;
    tag_d       = tag_q;
    crc_d       = crc_q;
    mod_d       = mod_q;
    req_rem_d   = req_rem_q;
    ret_rem_d   = ret_rem_q;
    first_d     = first_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (rd_pend_q) begin
      ret_rem_d = ret_rem_q - 12'd1;
      first_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (en_q && !cfifo_empty) begin
          cfifo_rdreq = 1'b1;
          state_d     = CWAIT;
        end
      end
      CWAIT: begin
        tag_d     = cfifo_q[CWIDTH-1:16];
        crc_d     = cfifo_q[15];
        mod_d     = desc_len[2:0];
        req_rem_d = desc_beats;
        ret_rem_d = desc_beats;
        first_d   = 1'b1;
        if (desc_len == '0) begin
          len_err = 1'b1;
          state_d = IDLE;
        end else if (cfifo_q[14]) begin
          state_d = DROP;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (!dfifo_empty && (req_rem_q != 12'd0) && (credit_used < 3'd2)) begin
          dfifo_rdreq = 1'b1;
        end
        if (pop && buf0_q.eop) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = IDLE;
        end
      end
      DROP: begin
        if (!dfifo_empty && (req_rem_q != 12'd0)) begin
          dfifo_rdreq = 1'b1;
        end
        if (rd_pend_q && last_ret) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dfifo_rdreq) begin
      req_rem_d = req_rem_q - 12'd1;
    end
  end

  // Two-entry output buffer; buf0 is always the head presented on TX.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = new_beat;
        end else begin
          buf1_d = new_beat;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = new_beat;
        end else begin
          buf0_d = buf1_q;
          buf1_d = new_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      tag_q      <= '0;
      crc_q      <= 1'b0;
      mod_q      <= '0;
      req_rem_q  <= '0;
      ret_rem_q  <= '0;
      first_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= 1'b1;
      tag_q      <= tag_d;
      crc_q      <= crc_d;
      mod_q      <= mod_d;
      req_rem_q  <= req_rem_d;
      ret_rem_q  <= ret_rem_d;
      first_q    <= first_d;
      rd_pend_q  <= dfifo_rdreq;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_data    = buf0_q.dat;
  assign tx_sop     = buf0_q.sop;
  assign tx_eop     = buf0_q.eop;
  assign tx_mod     = buf0_q.mod;
  assign tx_tag     = tag_q;
  assign tx_crc_ins = crc_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_br_pre_ctrl_rd.sv
// Bench for br_pre_ctrl_rd: behavioural control/data FIFOs feed the DUT, expected beats are queued at stimulus time and popped on each TX transfer.
module tb_br_pre_ctrl_rd;

  logic        clk = 1'b0;
  logic        reset_;
  logic        cfifo_rdreq;
  logic [39:0] cfifo_q;
  logic        cfifo_empty;
  logic        dfifo_rdreq;
  logic [63:0] dfifo_q;
  logic        dfifo_empty;
  logic        tx_val;
  logic        tx_rdy;
  logic [63:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic [2:0]  tx_mod;
  logic [23:0] tx_tag;
  logic        tx_crc_ins;
  logic        len_err;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  br_pre_ctrl_rd dut (
    .clk(clk), .reset_(reset_),
    .cfifo_rdreq(cfifo_rdreq), .cfifo_q(cfifo_q), .cfifo_empty(cfifo_empty),
    .dfifo_rdreq(dfifo_rdreq), .dfifo_q(dfifo_q), .dfifo_empty(dfifo_empty),
    .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_sop(tx_sop),
    .tx_eop(tx_eop), .tx_mod(tx_mod), .tx_tag(tx_tag), .tx_crc_ins(tx_crc_ins),
    .len_err(len_err), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  // Show-ahead-free FIFO models: q is valid the cycle after rdreq; reset flushes them.
  logic [39:0] cmem [0:255];
  logic [63:0] dmem [0:255];
  int cwr = 0, crd = 0, dwr = 0, drd = 0;
  logic d_hold = 1'b0;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      crd <= cwr;
      drd <= dwr;
    end else begin
      if (cfifo_rdreq) begin
        cfifo_q <= cmem[crd[7:0]];
        crd     <= crd + 1;
      end
      if (dfifo_rdreq) begin
        dfifo_q <= dmem[drd[7:0]];
        drd     <= drd + 1;
      end
    end
  end

  assign cfifo_empty = (crd == cwr);
  assign dfifo_empty = (drd == dwr) || d_hold;

  typedef struct packed {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [23:0] tag;
    logic        crc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int cyc_n = 0, crd_cyc = 0, sop_cyc = 0, eop_cyc = 0;
  int n_crd = 0, n_drd = 0, n_lerr = 0, out_cnt = 0;
  logic chk_occ = 1'b0, stall_prev = 1'b0, val_prev = 1'b0;
  logic [63:0] prev_dat = '0;
  logic prev_sop = 1'b0, prev_eop = 1'b0;
  logic [2:0] prev_mod = '0;

  function automatic logic [63:0] dword(input int k);
    return {16'hDA7A, k[15:0], ~k};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    cyc_n++;
    if (cfifo_rdreq) begin
      n_crd++;
      crd_cyc = cyc_n;
      chk("cfifo_rd_while_empty", 64'(cfifo_empty), 64'(0));
    end
    if (dfifo_rdreq) begin
      n_drd++;
      chk("dfifo_rd_while_empty", 64'(dfifo_empty), 64'(0));
    end
    if (d_hold) chk("rd_during_hold", 64'(dfifo_rdreq), 64'(0));
    if (len_err) n_lerr++;
    if (stall_prev) begin
      chk("stall_val", 64'(tx_val), 64'(1));
      chk("stall_data", tx_data, prev_dat);
      chk("stall_sop", 64'(tx_sop), 64'(prev_sop));
      chk("stall_eop", 64'(tx_eop), 64'(prev_eop));
      chk("stall_mod", 64'(tx_mod), 64'(prev_mod));
    end
    if (chk_occ) chk("occ_plus_inflight_le2", 64'(out_cnt <= 2), 64'(1));
    if (tx_val && tx_sop && !val_prev) sop_cyc = cyc_n;
    if (tx_val && tx_rdy) begin
      chk("beat_expected", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("tx_data", tx_data, e.dat);
        chk("tx_sop", 64'(tx_sop), 64'(e.sop));
        chk("tx_eop", 64'(tx_eop), 64'(e.eop));
        chk("tx_mod", 64'(tx_mod), 64'(e.mod));
        chk("tx_tag", 64'(tx_tag), 64'(e.tag));
        chk("tx_crc_ins", 64'(tx_crc_ins), 64'(e.crc));
      end
      if (tx_eop) eop_cyc = cyc_n;
    end
    if (chk_occ) out_cnt = out_cnt + int'(dfifo_rdreq) - int'(tx_val && tx_rdy);
    stall_prev = tx_val && !tx_rdy;
    val_prev   = tx_val;
    prev_dat   = tx_data;
    prev_sop   = tx_sop;
    prev_eop   = tx_eop;
    prev_mod   = tx_mod;
  endtask

  // Inputs change at posedge+1; the monitor samples at the following negedge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_data(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      dmem[dwr[7:0]] = dword(base + i);
      dwr++;
    end
  endtask

  task automatic push_desc(input int len, input logic drop, input logic crc, input logic [23:0] tag);
    cmem[cwr[7:0]] = {tag, crc, drop, len[13:0]};
    cwr++;
  endtask

  task automatic exp_pkt(input int len, input logic [23:0] tag, input logic crc, input int base);
    exp_t e;
    int n;
    n = (len + 7) / 8;
    for (int i = 0; i < n; i++) begin
      e.dat = dword(base + i);
      e.sop = (i == 0);
      e.eop = (i == n - 1);
      e.mod = (i == n - 1) ? 3'(len % 8) : 3'd0;
      e.tag = tag;
      e.crc = crc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_depth(input string tag, input int depth, input int budget);
    int n;
    n = 0;
    while (sbq.size() > depth && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 64'(sbq.size() <= depth), 64'(1));
  endtask

  initial begin
    int lerr0, drd0, crd0;
    logic [3:0] pat;

    reset_ = 1'b0;
    tx_rdy = 1'b0;
    repeat (3) cyc();
    chk("rst_cfifo_rdreq", 64'(cfifo_rdreq), 64'(0));
    chk("rst_dfifo_rdreq", 64'(dfifo_rdreq), 64'(0));
    chk("rst_tx_val", 64'(tx_val), 64'(0));
    chk("rst_tx_data", tx_data, 64'(0));
    chk("rst_tx_sop_eop_mod", 64'({tx_sop, tx_eop, tx_mod}), 64'(0));
    chk("rst_tx_tag", 64'(tx_tag), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    reset_ = 1'b1;
    repeat (2) cyc();

    // Single packet, L=20: three beats, mod 4 on the last.
    tx_rdy = 1'b1;
    push_data(0, 3);
    exp_pkt(20, 24'hABCDEF, 1'b1, 0);
    push_desc(20, 1'b0, 1'b1, 24'hABCDEF);
    wait_depth("t1_drain", 0, 40);
    chk("t1_latency", 64'(sop_cyc - crd_cyc), 64'(4));
    repeat (2) cyc();
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(1));

    // Back-to-back L=8 then L=64.
    push_data(3, 9);
    exp_pkt(8, 24'h000111, 1'b0, 3);
    exp_pkt(64, 24'h000222, 1'b1, 4);
    push_desc(8, 1'b0, 1'b0, 24'h000111);
    push_desc(64, 1'b0, 1'b1, 24'h000222);
    wait_depth("t2_drain", 0, 60);
    chk("t2_contiguous", 64'(eop_cyc - sop_cyc), 64'(7));
    repeat (2) cyc();
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(3));

    // L=40 with tx_rdy cycling 1,0,0,1.
    pat = 4'b1001;
    out_cnt = 0;
    chk_occ = 1'b1;
    push_data(12, 5);
    exp_pkt(40, 24'h00C0DE, 1'b0, 12);
    push_desc(40, 1'b0, 1'b0, 24'h00C0DE);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
      tx_rdy = pat[i % 4];
      cyc();
    end
    chk("t3_drain", 64'(sbq.size()), 64'(0));
    chk_occ = 1'b0;
    tx_rdy = 1'b1;
    repeat (2) cyc();
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'(4));

    // Dropped L=24, then a normal L=16 starting at the fourth word.
    push_data(17, 5);
    exp_pkt(16, 24'h000444, 1'b1, 20);
    push_desc(24, 1'b1, 1'b0, 24'h000333);
    push_desc(16, 1'b0, 1'b1, 24'h000444);
    wait_depth("t4_drain", 0, 60);
    repeat (2) cyc();
    chk("t4_drop_cnt", 64'(drop_cnt), 64'(1));
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(5));
    chk("t4_dfifo_consumed", 64'(drd), 64'(22));

    // Zero-length descriptor, then a normal one.
    lerr0 = n_lerr;
    drd0  = n_drd;
    crd0  = n_crd;
    push_desc(0, 1'b0, 1'b0, 24'h000555);
    repeat (8) cyc();
    chk("t5_len_err_cycles", 64'(n_lerr - lerr0), 64'(1));
    chk("t5_no_dfifo_rd", 64'(n_drd - drd0), 64'(0));
    chk("t5_one_pop", 64'(n_crd - crd0), 64'(1));
    push_data(22, 1);
    exp_pkt(5, 24'h000666, 1'b0, 22);
    push_desc(5, 1'b0, 1'b0, 24'h000666);
    wait_depth("t5_drain", 0, 40);
    repeat (2) cyc();
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(6));

    // L=48: data FIFO looks empty for 5 cycles mid-packet, then reset mid-packet.
    push_data(23, 6);
    exp_pkt(48, 24'h000777, 1'b0, 23);
    push_desc(48, 1'b0, 1'b0, 24'h000777);
    wait_depth("t6_pre_hold", 4, 40);
    d_hold = 1'b1;
    repeat (5) cyc();
    chk("t6_buffered_drained", 64'(sbq.size()), 64'(2));
    d_hold = 1'b0;
    wait_depth("t6_resume", 1, 30);
    #2;
    reset_ = 1'b0;
    #1;
    chk("arst_cfifo_rdreq", 64'(cfifo_rdreq), 64'(0));
    chk("arst_dfifo_rdreq", 64'(dfifo_rdreq), 64'(0));
    chk("arst_tx_val", 64'(tx_val), 64'(0));
    chk("arst_tx_data", tx_data, 64'(0));
    chk("arst_tx_sop_eop_mod", 64'({tx_sop, tx_eop, tx_mod}), 64'(0));
    chk("arst_tx_tag_crc", 64'({tx_tag, tx_crc_ins}), 64'(0));
    chk("arst_pkt_cnt", 64'(pkt_cnt), 64'(6'd0));
    chk("arst_drop_cnt", 64'(drop_cnt), 64'(0));
    sbq.delete();
    repeat (2) cyc();
    reset_ = 1'b1;

    // Back in IDLE: a fresh packet goes through with normal latency.
    push_data(29, 1);
    exp_pkt(3, 24'h000888, 1'b1, 29);
    push_desc(3, 1'b0, 1'b1, 24'h000888);
    wait_depth("t7_drain", 0, 40);
    chk("t7_latency", 64'(sop_cyc - crd_cyc), 64'(4));
    repeat (2) cyc();
    chk("t7_pkt_cnt", 64'(pkt_cnt), 64'(1));
    chk("t7_drop_cnt", 64'(drop_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
